// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency load/store responder over word-organised storage
package isa_types;
   localparam int XLEN = 32;
   typedef enum logic [1:0] {
      WRITE_BYTE     = 2'd0,
      WRITE_HALFWORD = 2'd1,
      WRITE_WORD     = 2'd2
   } write_width_t;
endpackage

module data_mem_responder
   import isa_types::*;
#(
   parameter int XLEN        = isa_types::XLEN,
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [XLEN-1:0]   req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   input  write_width_t      req_width,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_error
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t            state, next_state;
   logic [3:0]        count;
   logic              lat_write;
   logic [XLEN-1:0]   lat_addr;
   logic [XLEN-1:0]   lat_wdata;
   write_width_t      lat_width;
   logic [XLEN-1:0]   mem [DEPTH_WORDS];

   logic              acc_write;
   logic [XLEN-1:0]   acc_addr;
   logic [XLEN-1:0]   acc_wdata;
   write_width_t      acc_width;
   logic [IDX_W-1:0]  acc_idx;
   logic              acc_error;
   logic [3:0]        acc_be;
   logic [XLEN-1:0]   acc_wshift;
   logic [XLEN-1:0]   acc_rdata;
   logic              commit;

   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               next_state = (LATENCY > 1) ? S_WAIT : S_RESP;
         end
         S_WAIT: begin
            if (count == 4'd1)
               next_state = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            if (resp_ready)
               next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

   // With LATENCY=1 the commit happens on the accept edge, so the access comes straight from the request.
   always_comb begin
      acc_write = (state == S_IDLE) ? req_write : lat_write;
      acc_addr  = (state == S_IDLE) ? req_addr  : lat_addr;
      acc_wdata = (state == S_IDLE) ? req_wdata : lat_wdata;
      acc_width = (state == S_IDLE) ? req_width : lat_width;
      acc_idx   = acc_addr[IDX_W+1:2];
      acc_error = ((acc_width == WRITE_HALFWORD) && acc_addr[0])
               || ((acc_width == WRITE_WORD) && (acc_addr[1:0] != 2'b00))
               || ({2'b00, acc_addr[XLEN-1:2]} >= XLEN'(DEPTH_WORDS));
      acc_be = 4'b0000;
      case (acc_width)
         WRITE_BYTE:     acc_be = 4'b0001 << acc_addr[1:0];
         WRITE_HALFWORD: acc_be = 4'b0011 << {acc_addr[1], 1'b0};
         WRITE_WORD:     acc_be = 4'b1111;
         default:        acc_be = 4'b0000;
      endcase
      acc_wshift = acc_wdata << {acc_addr[1:0], 3'b000};
      acc_rdata  = mem[acc_idx] >> {acc_addr[1:0], 3'b000};
      case (acc_width)
         WRITE_BYTE:     acc_rdata = acc_rdata & XLEN'(32'h0000_00FF);
         WRITE_HALFWORD: acc_rdata = acc_rdata & XLEN'(32'h0000_FFFF);
         default:        acc_rdata = acc_rdata;
      endcase
      commit = !reset && (state != S_RESP) && (next_state == S_RESP);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         count      <= 4'd0;
         lat_write  <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_width  <= WRITE_BYTE;
         resp_rdata <= '0;
         resp_error <= 1'b0;
      end else begin
         state <= next_state;
         if (state == S_IDLE && req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_width <= req_width;
            count     <= CNT_INIT;
         end else if (state == S_WAIT) begin
            count <= count - 4'd1;
         end
         if (commit) begin
            resp_error <= acc_error;
            resp_rdata <= (!acc_write && !acc_error) ? acc_rdata : '0;
         end else if (state == S_RESP && resp_ready) begin
            resp_error <= 1'b0;
            resp_rdata <= '0;
         end
      end
   end

   // Storage is deliberately outside the reset domain; a committed store survives reset.
   always_ff @(posedge clock) begin
      if (commit && acc_write && !acc_error) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i])
               mem[acc_idx][8*i +: 8] <= acc_wshift[8*i +: 8];
         end
      end
   end

endmodule
